key_search_ctrl: RTL and testbench

Sequencer that drives the brute-force key search of the 64-bit-block / 128-bit-key header decryptor.
- Generates candidate keys `key_base + i` and streams them with the latched encrypted header into a pipelined decryptor over a valid/ready handshake.
- Tracks in-flight candidates in an internal FIFO and checks every decrypted result against a masked expected plaintext.
- Reports the first matching key. Sits between the top-level key breaker and the decryptor core.

---
 rtl/key_search_ctrl_if.sv | 26 ++
 rtl/key_search_ctrl.sv | 146 ++++++++++++++
 tb/tb_key_search_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_search_ctrl_if.sv
// ============================================================================
// key_search_ctrl_if : candidate/result channel between search sequencer and
// pipelined header decryptor.                                     Rev 1.0
// ============================================================================
`default_nettype none

interface key_search_ctrl_if;
  logic [127:0] dec_key;
  logic [63:0]  dec_block;
  logic         dec_valid;
  logic         dec_ready;
  logic [63:0]  dec_out;
  logic         dec_out_valid;

  modport master (
    output dec_key, dec_block, dec_valid,
    input  dec_ready, dec_out, dec_out_valid
  );

  modport slave (
    input  dec_key, dec_block, dec_valid,
    output dec_ready, dec_out, dec_out_valid
  );
endinterface

`default_nettype wire

// File: rtl/key_search_ctrl.sv
// ============================================================================
// key_search_ctrl : brute-force key search sequencer with in-flight key FIFO.
// Optional feature macro: KSC_ABORT_EN (adds abort input).        Rev 1.0
// ============================================================================
`default_nettype none

module key_search_ctrl #(
  parameter int CNT_W      = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [127:0]     key_base,
  input  logic [CNT_W-1:0] key_count,
  input  logic [63:0]      header,
  input  logic [63:0]      expected,
  input  logic [63:0]      expected_mask,
`ifdef KSC_ABORT_EN
  input  logic             abort,
`endif
  key_search_ctrl_if.master dec,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [127:0]     proper_key,
  output logic [CNT_W-1:0] tried
);

  localparam int             PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] c_DEPTH = (PTR_W+1)'(FIFO_DEPTH);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_RUN   = 2'd1;
  localparam logic [1:0] c_DRAIN = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [127:0]     key_base_q;
  logic [CNT_W-1:0] count_q, issued_q, tried_q;
  logic [63:0]      header_q, expected_q, mask_q;
  logic             found_q;
  logic [127:0]     proper_key_q;
  logic [127:0]     fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [PTR_W:0]   occ_q, occ_d;

  logic w_run, w_full, w_empty, w_valid, w_push, w_pop, w_hit, w_abort;

  assign w_run   = (state_q == c_RUN);
  assign w_full  = (occ_q == c_DEPTH);
  assign w_empty = (occ_q == '0);
  assign w_push  = w_valid && dec.dec_ready;
  assign w_pop   = dec.dec_out_valid && !w_empty;
  // Results come back in issue order, so the FIFO head is the key that produced dec_out.
  assign w_hit   = w_pop && w_run && (((dec.dec_out ^ expected_q) & mask_q) == '0);
  assign occ_d   = occ_q + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);

`ifdef KSC_ABORT_EN
  assign w_abort = w_run && abort;
`else
  assign w_abort = 1'b0;
`endif

  assign dec.dec_key   = key_base_q + 128'(issued_q);
  assign dec.dec_block = header_q;
  assign dec.dec_valid = w_valid;
  assign found         = found_q;
  assign proper_key    = proper_key_q;
  assign tried         = tried_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= c_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE:  if (start) state_d = (key_count == '0) ? c_DONE : c_RUN;
      c_RUN: begin
        if (w_hit || w_abort)                          state_d = c_DRAIN;
        else if ((issued_q == count_q) && (occ_d == '0)) state_d = c_DONE;
      end
      c_DRAIN: if (occ_d == '0) state_d = c_DONE;
      c_DONE:  state_d = c_IDLE;
      default: state_d = c_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != c_IDLE);
    done    = (state_q == c_DONE);
    w_valid = w_run && (issued_q < count_q) && !w_full;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      key_base_q   <= '0;
      count_q      <= '0;
      header_q     <= '0;
      expected_q   <= '0;
      mask_q       <= '0;
      issued_q     <= '0;
      tried_q      <= '0;
      found_q      <= 1'b0;
      proper_key_q <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      occ_q        <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      if ((state_q == c_IDLE) && start) begin
        key_base_q   <= key_base;
        count_q      <= key_count;
        header_q     <= header;
        expected_q   <= expected;
        mask_q       <= expected_mask;
        issued_q     <= '0;
        tried_q      <= '0;
        found_q      <= 1'b0;
        proper_key_q <= '0;
      end
      if (w_push) begin
        fifo_q[wr_ptr_q] <= dec.dec_key;
        wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
        issued_q         <= issued_q + CNT_W'(1);
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        if (w_run) tried_q <= tried_q + CNT_W'(1);
      end
      if (w_hit) begin
        found_q      <= 1'b1;
        proper_key_q <= fifo_q[rd_ptr_q];
      end
      occ_q <= occ_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_key_search_ctrl.sv
// ============================================================================
// tb_key_search_ctrl : randomized bench with mock fixed-latency decryptor and
// a first-match reference model.                                 Rev 1.0
// ============================================================================
`default_nettype none

module tb_key_search_ctrl;
  localparam int CNT_W      = 32;
  localparam int FIFO_DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [127:0]     key_base = '0;
  logic [CNT_W-1:0] key_count = '0;
  logic [63:0]      header = '0;
  logic [63:0]      expected = '0;
  logic [63:0]      expected_mask = '0;
  logic             busy, done, found;
  logic [127:0]     proper_key;
  logic [CNT_W-1:0] tried;
`ifdef KSC_ABORT_EN
  logic             abort = 1'b0;
`endif

  key_search_ctrl_if dif();

  key_search_ctrl #(.CNT_W(CNT_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .key_base(key_base), .key_count(key_count),
    .header(header), .expected(expected), .expected_mask(expected_mask),
`ifdef KSC_ABORT_EN
    .abort(abort),
`endif
    .dec(dif), .busy(busy), .done(done), .found(found), .proper_key(proper_key), .tried(tried)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Bench-owned controls for the monitor
  int lat = 3;
  int ready_mode = 0;
  bit orphan_ok = 1'b0;
  int mon_clr = 0;

  // Monitor-owned state
  int           cyc = 0, occ = 0, max_occ = 0, clr_seen = 0;
  int           done_cnt = 0, done_cyc = -1, last_pop_cyc = -1, valid_seen = 0;
  int           stab_viol = 0, full_viol = 0, proto_viol = 0;
  bit           stall_prev = 1'b0;
  logic [127:0] stall_key = '0;
  logic [127:0] xfer_q[$];
  logic [63:0]  pipe_dat[$];
  int           pipe_due[$];

  function automatic logic [63:0] mockdec(input logic [127:0] k, input logic [63:0] h);
    return k[63:0] ^ {k[95:64], k[127:96]} ^ h ^ 64'hA5C3_0F1E_5A3C_F0E1;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Reference: index of the first candidate whose masked decryption matches, or -1.
  function automatic int ref_first_match(input logic [127:0] base, input int cnt,
                                         input logic [63:0] hdr, input logic [63:0] exp,
                                         input logic [63:0] mask);
    for (int i = 0; i < cnt; i++)
      if (((mockdec(base + 128'(i), hdr) ^ exp) & mask) == 64'd0) return i;
    return -1;
  endfunction

  // Mock decryptor and protocol monitor; decisions are made mid-cycle for the next edge.
  always @(negedge clk) begin
    bit xfer, popv;
    cyc++;
    if (mon_clr != clr_seen) begin
      clr_seen = mon_clr;
      done_cnt = 0; done_cyc = -1; last_pop_cyc = -1; valid_seen = 0;
      stab_viol = 0; full_viol = 0; proto_viol = 0; max_occ = 0;
      xfer_q.delete();
    end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (dif.dec_valid) valid_seen++;
    if (occ >= FIFO_DEPTH && dif.dec_valid) full_viol++;
    if (stall_prev && dif.dec_valid && dif.dec_key !== stall_key) stab_viol++;
    case (ready_mode)
      0:       dif.dec_ready = 1'b1;
      1:       dif.dec_ready = (dif.dec_ready === 1'b1) ? 1'b0 : 1'b1;
      default: dif.dec_ready = 1'($urandom_range(0, 1));
    endcase
    stall_prev = dif.dec_valid && !dif.dec_ready;
    stall_key  = dif.dec_key;
    xfer = (dif.dec_valid === 1'b1) && (dif.dec_ready === 1'b1);
    if (xfer) begin
      xfer_q.push_back(dif.dec_key);
      pipe_dat.push_back(mockdec(dif.dec_key, dif.dec_block));
      pipe_due.push_back(cyc + lat);
    end
    popv = 1'b0;
    dif.dec_out_valid = 1'b0;
    if (pipe_due.size() > 0 && pipe_due[0] <= cyc) begin
      dif.dec_out = pipe_dat.pop_front();
      void'(pipe_due.pop_front());
      dif.dec_out_valid = 1'b1;
      if (occ == 0 && !orphan_ok) proto_viol++;
      if (occ > 0) begin popv = 1'b1; last_pop_cyc = cyc; end
    end
    occ = occ + int'(xfer) - int'(popv);
    if (!rst) occ = 0;
    if (occ > max_occ) max_occ = occ;
  end

  task automatic run_search(input logic [127:0] base, input int cnt, input logic [63:0] hdr,
                            input logic [63:0] exp, input logic [63:0] mask,
                            input int l, input int rmode, input string name);
    int idx, to, bad, nx;
    logic [127:0] want_key;
    idx = ref_first_match(base, cnt, hdr, exp, mask);
    want_key = (idx >= 0) ? base + 128'(idx) : 128'd0;
    @(posedge clk); #2;
    lat = l; ready_mode = rmode; mon_clr++;
    key_base = base; key_count = CNT_W'(cnt); header = hdr; expected = exp; expected_mask = mask;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    key_base = rnd128(); header = {$urandom(), $urandom()}; expected = ~exp;
    to = 0;
    while (done_cnt == 0 && to < 3000) begin @(posedge clk); #2; to++; end
    checks++;
    if (done_cnt == 0) begin errors++; $display("FAIL %s done_timeout: got none, want 1 pulse", name); end
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL %s done_count: got %0d want 1", name, done_cnt); end
    checks++;
    if (found !== (idx >= 0)) begin errors++; $display("FAIL %s found: got %b want %b", name, found, idx >= 0); end
    checks++;
    if (proper_key !== want_key) begin errors++; $display("FAIL %s proper_key: got %h want %h", name, proper_key, want_key); end
    checks++;
    if (tried !== CNT_W'((idx >= 0) ? idx + 1 : cnt)) begin
      errors++; $display("FAIL %s tried: got %0d want %0d", name, tried, (idx >= 0) ? idx + 1 : cnt);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_after: got %b want 0", name, busy); end
    nx = xfer_q.size();
    checks++;
    if ((idx < 0 && nx != cnt) || (idx >= 0 && (nx < idx + 1 || nx > cnt))) begin
      errors++; $display("FAIL %s transfers: got %0d want %0d (match idx %0d)", name, nx, cnt, idx);
    end
    bad = 0;
    foreach (xfer_q[j]) if (xfer_q[j] !== base + 128'(j)) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL %s key_sequence: got %0d wrong keys want 0", name, bad); end
    checks++;
    if (stab_viol != 0 || full_viol != 0 || proto_viol != 0) begin
      errors++; $display("FAIL %s protocol: got stall=%0d full=%0d orphan=%0d want 0", name, stab_viol, full_viol, proto_viol);
    end
    if (idx < 0) begin
      checks++;
      if (done_cyc != last_pop_cyc + 1) begin
        errors++; $display("FAIL %s done_latency: got cycle %0d want %0d", name, done_cyc, last_pop_cyc + 1);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b want 0", done); end
    checks++; if (found !== 1'b0) begin errors++; $display("FAIL reset found: got %b want 0", found); end
    checks++; if (proper_key !== '0) begin errors++; $display("FAIL reset proper_key: got %h want 0", proper_key); end
    checks++; if (tried !== '0) begin errors++; $display("FAIL reset tried: got %0d want 0", tried); end
    checks++; if (dif.dec_valid !== 1'b0) begin errors++; $display("FAIL reset dec_valid: got %b want 0", dif.dec_valid); end
    checks++; if (dif.dec_key !== '0) begin errors++; $display("FAIL reset dec_key: got %h want 0", dif.dec_key); end
    checks++; if (dif.dec_block !== '0) begin errors++; $display("FAIL reset dec_block: got %h want 0", dif.dec_block); end
    rst = 1'b1;
  endtask

  task automatic test_match();
    logic [127:0] b;
    logic [63:0]  h;
    b = 128'hDEAD_BEEF_0000_0000_0000_0000_0000_00F0;
    h = 64'h0123_4567_89AB_CDEF;
    run_search(b, 16, h, mockdec(b + 128'd5, h), '1, 3, 0, "match5");
  endtask

  task automatic test_zero_count();
    @(posedge clk); #2;
    mon_clr++; key_count = '0; key_base = rnd128(); start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_count done: got %b want 1", done); end
    checks++; if (found !== 1'b0) begin errors++; $display("FAIL zero_count found: got %b want 0", found); end
    @(posedge clk); #2;
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL zero_count end: got done=%b busy=%b want 0 0", done, busy);
    end
    repeat (3) @(posedge clk);
    #2;
    checks++; if (tried !== '0) begin errors++; $display("FAIL zero_count tried: got %0d want 0", tried); end
    checks++; if (valid_seen != 0 || done_cnt != 1) begin
      errors++; $display("FAIL zero_count valid/done: got valid=%0d done=%0d want 0 1", valid_seen, done_cnt);
    end
  endtask

  task automatic test_nomatch_wrap();
    logic [127:0] b;
    logic [63:0]  h;
    b = '1;
    b = b - 128'd1;
    h = {$urandom(), $urandom()};
    run_search(b, 16, h, ~mockdec(b, h), '1, 2, 0, "nomatch_wrap");
  endtask

  task automatic test_stall();
    logic [127:0] b;
    logic [63:0]  h;
    b = rnd128();
    h = {$urandom(), $urandom()};
    run_search(b, 20, h, mockdec(b + 128'd14, h), '1, 4, 1, "stall_match");
    run_search(b, 12, h, ~mockdec(b, h), '1, 2, 1, "stall_nomatch");
  endtask

  task automatic test_fifo_full();
    logic [127:0] b;
    logic [63:0]  h;
    b = rnd128();
    h = {$urandom(), $urandom()};
    run_search(b, 16, h, ~mockdec(b, h), '1, 20, 0, "fifo_full");
    checks++;
    if (max_occ != FIFO_DEPTH) begin errors++; $display("FAIL fifo_full max_inflight: got %0d want %0d", max_occ, FIFO_DEPTH); end
  endtask

  task automatic test_zero_mask();
    run_search(rnd128(), 10, {$urandom(), $urandom()}, {$urandom(), $urandom()}, '0, 5, 2, "zero_mask");
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      logic [127:0] b;
      logic [63:0]  h, e, m;
      int           cnt;
      b   = rnd128();
      h   = {$urandom(), $urandom()};
      cnt = $urandom_range(1, 30);
      m   = ($urandom_range(0, 1) == 0) ? '1 : {$urandom(), $urandom()};
      if ($urandom_range(0, 2) != 0) e = mockdec(b + 128'($urandom_range(0, cnt - 1)), h);
      else                           e = {$urandom(), $urandom()};
      run_search(b, cnt, h, e, m, $urandom_range(1, 12), $urandom_range(0, 2), "random");
    end
  endtask

  task automatic test_reset_mid();
    int to, bad;
    @(posedge clk); #2;
    lat = 10; ready_mode = 0; mon_clr++;
    key_base = rnd128(); key_count = 40; header = {$urandom(), $urandom()};
    expected = '0; expected_mask = '1; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    to = 0;
    while (occ < 5 && to < 100) begin @(posedge clk); #2; to++; end
    checks++; if (occ != 5) begin errors++; $display("FAIL reset_mid inflight: got %0d want 5", occ); end
    orphan_ok = 1'b1;
    rst = 1'b0;
    @(posedge clk); #2;
    checks++;
    if (busy !== 0 || done !== 0 || found !== 0 || tried !== '0 || proper_key !== '0 ||
        dif.dec_valid !== 0 || dif.dec_key !== '0 || dif.dec_block !== '0) begin
      errors++; $display("FAIL reset_mid outputs: got busy=%b valid=%b tried=%0d key=%h want all 0",
                         busy, dif.dec_valid, tried, dif.dec_key);
    end
    rst = 1'b1;
    bad = 0; to = 0;
    while (pipe_due.size() > 0 && to < 100) begin
      @(posedge clk); #2; to++;
      if (busy !== 0 || found !== 0 || tried !== '0 || dif.dec_valid !== 0) bad++;
    end
    checks++;
    if (bad != 0 || pipe_due.size() != 0) begin
      errors++; $display("FAIL reset_mid late_results: got %0d bad cycles, %0d pending want 0 0", bad, pipe_due.size());
    end
    repeat (2) @(posedge clk);
    #2;
    orphan_ok = 1'b0;
    run_search(rnd128(), 9, 64'h55AA_55AA_0000_FFFF, 64'd0, '0, 3, 0, "after_reset");
  endtask

`ifdef KSC_ABORT_EN
  task automatic test_abort();
    int to;
    logic [127:0] b;
    b = rnd128();
    @(posedge clk); #2;
    lat = 6; ready_mode = 0; mon_clr++;
    key_base = b; key_count = 20; header = '0; expected = ~mockdec(b, 64'd0); expected_mask = '1;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    to = 0;
    while (xfer_q.size() < 3 && to < 50) begin @(posedge clk); #2; to++; end
    abort = 1'b1;
    @(posedge clk); #2;
    abort = 1'b0;
    to = 0;
    while (done_cnt == 0 && to < 200) begin @(posedge clk); #2; to++; end
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (found !== 1'b0 || done_cnt != 1 || busy !== 1'b0 || xfer_q.size() >= 20) begin
      errors++; $display("FAIL abort: got found=%b done=%0d busy=%b xfers=%0d want 0 1 0 <20",
                         found, done_cnt, busy, xfer_q.size());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_match();
    test_zero_count();
    test_nomatch_wrap();
    test_stall();
    test_fifo_full();
    test_zero_mask();
    test_random();
    test_reset_mid();
`ifdef KSC_ABORT_EN
    test_abort();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
